// File: rtl/bpfvm_verdict_queue.sv
// Verdict FIFO between the BPF CPU controller and the packet forwarder.
// Optional statistics counters are built only when VERDICT_STATS_EN is defined.
module bpfvm_verdict_queue #(
  parameter int DEPTH     = 4,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 reject,
  input  logic [LEN_WIDTH-1:0] byte_len,
  output logic                 verdict_full,
  output logic                 cpu_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_accept,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 proto_err,
  output logic [CNT_WIDTH-1:0] accept_count,
  output logic [CNT_WIDTH-1:0] reject_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = LEN_WIDTH + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, done_reg, err_reg;
  logic          verdict_event, verdict_value, push, pop, drop;

  always_comb begin
    verdict_event = accept | reject;
    verdict_value = ~reject;
    pop           = out_valid & out_ready;
    push          = verdict_event & (~full_reg | pop);
    drop          = verdict_event & full_reg & ~pop;
    count_next    = count_reg;
    if (push && !pop)
      count_next = count_reg + (AW+1)'(1);
    else if (!push && pop)
      count_next = count_reg - (AW+1)'(1);
  end

  // Storage carries no reset; outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {verdict_value, byte_len};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      done_reg  <= push;
      if (drop || (accept && reject))
        err_reg <= 1'b1;
    end
  end

  assign verdict_full = full_reg;
  assign cpu_done     = done_reg;
  assign proto_err    = err_reg;
  assign out_valid    = (count_reg != '0);
  assign out_accept   = out_valid & mem[rd_ptr_reg][EW-1];
  assign out_len      = out_valid ? mem[rd_ptr_reg][LEN_WIDTH-1:0] : '0;

`ifdef VERDICT_STATS_EN
  logic [CNT_WIDTH-1:0] acc_cnt_reg, rej_cnt_reg, drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_cnt_reg  <= '0;
      rej_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (push && verdict_value)
        acc_cnt_reg <= acc_cnt_reg + CNT_WIDTH'(1);
      if (push && !verdict_value)
        rej_cnt_reg <= rej_cnt_reg + CNT_WIDTH'(1);
      if (drop)
        drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign accept_count = acc_cnt_reg;
  assign reject_count = rej_cnt_reg;
  assign drop_count   = drop_cnt_reg;
`else
  assign accept_count = '0;
  assign reject_count = '0;
  assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_bpfvm_verdict_queue.sv
// Directed self-checking bench for bpfvm_verdict_queue (DEPTH=4).
module tb_bpfvm_verdict_queue;

`ifdef VERDICT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        accept = 1'b0;
  logic        reject = 1'b0;
  logic [15:0] byte_len = '0;
  logic        out_ready = 1'b0;
  logic        verdict_full, cpu_done, out_valid, out_accept, proto_err;
  logic [15:0] out_len;
  logic [31:0] accept_count, reject_count, drop_count;

  int checks = 0;
  int errors = 0;

  bpfvm_verdict_queue #(.DEPTH(4), .LEN_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .accept(accept), .reject(reject), .byte_len(byte_len),
    .verdict_full(verdict_full), .cpu_done(cpu_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_accept(out_accept), .out_len(out_len),
    .proto_err(proto_err), .accept_count(accept_count),
    .reject_count(reject_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic a, input logic r, input logic [15:0] len);
    accept = a; reject = r; byte_len = len;
    tick();
    accept = 1'b0; reject = 1'b0; byte_len = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    checks++;
    if ({verdict_full, cpu_done, out_valid, out_accept, proto_err} !== 5'b0 || out_len !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got full=%b done=%b valid=%b acc=%b err=%b len=%0d, want all 0",
               verdict_full, cpu_done, out_valid, out_accept, proto_err, out_len);
    end
    checks++;
    if (accept_count !== 0 || reject_count !== 0 || drop_count !== 0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, want 0/0/0", accept_count, reject_count, drop_count);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push_one(1'b1, 1'b0, 16'd64);
    checks++;
    if (out_valid !== 1'b1 || out_accept !== 1'b1 || out_len !== 16'd64 || cpu_done !== 1'b1) begin
      errors++;
      $display("FAIL single_head: got valid=%b acc=%b len=%0d done=%b, want 1 1 64 1",
               out_valid, out_accept, out_len, cpu_done);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || cpu_done !== 1'b0 || accept_count !== 32'(STATS)) begin
      errors++;
      $display("FAIL single_drain: got valid=%b done=%b acc_cnt=%0d, want 0 0 %0d",
               out_valid, cpu_done, accept_count, STATS);
    end
    $display("test_single: accept len=64 delivered");
  endtask

  task automatic test_fill_drop_drain();
    logic        exp_a [4];
    logic [15:0] exp_l [4];
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_l = '{16'd10, 16'd20, 16'd30, 16'd40};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_one(exp_a[i], ~exp_a[i], exp_l[i]);
    checks++;
    if (verdict_full !== 1'b1 || cpu_done !== 1'b1 || proto_err !== 1'b0 || out_len !== 16'd10) begin
      errors++;
      $display("FAIL fill_full: got full=%b done=%b err=%b len=%0d, want 1 1 0 10",
               verdict_full, cpu_done, proto_err, out_len);
    end
    push_one(1'b1, 1'b0, 16'd50);
    checks++;
    if (proto_err !== 1'b1 || cpu_done !== 1'b0 || verdict_full !== 1'b1 ||
        drop_count !== 32'(STATS) || out_accept !== 1'b1 || out_len !== 16'd10) begin
      errors++;
      $display("FAIL drop: got err=%b done=%b full=%b drop_cnt=%0d head=%b/%0d, want 1 0 1 %0d 1/10",
               proto_err, cpu_done, verdict_full, drop_count, out_accept, out_len, STATS);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_accept !== exp_a[i] || out_len !== exp_l[i]) begin
        errors++;
        $display("FAIL drain_%0d: got valid=%b %b/%0d, want 1 %b/%0d",
                 i, out_valid, out_accept, out_len, exp_a[i], exp_l[i]);
      end
      $display("drain %0d: %b/%0d", i, out_accept, out_len);
      tick();
      if (i == 0) begin
        checks++;
        if (verdict_full !== 1'b0) begin
          errors++;
          $display("FAIL full_fall: got %b, want 0", verdict_full);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] exp_l [4];
    logic        exp_a [4];
    exp_l = '{16'd2, 16'd3, 16'd4, 16'd5};
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 1; i <= 4; i++)
      push_one(1'b1, 1'b0, 16'(i));
    out_ready = 1'b1;
    push_one(1'b0, 1'b1, 16'd5);
    checks++;
    if (verdict_full !== 1'b1 || cpu_done !== 1'b1 || proto_err !== 1'b0 || out_len !== 16'd2) begin
      errors++;
      $display("FAIL full_pop: got full=%b done=%b err=%b len=%0d, want 1 1 0 2",
               verdict_full, cpu_done, proto_err, out_len);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_accept !== exp_a[i] || out_len !== exp_l[i]) begin
        errors++;
        $display("FAIL wrap_%0d: got valid=%b %b/%0d, want 1 %b/%0d",
                 i, out_valid, out_accept, out_len, exp_a[i], exp_l[i]);
      end
      $display("wrap drain %0d: %b/%0d", i, out_accept, out_len);
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || verdict_full !== 1'b0 ||
        accept_count !== 32'(4*STATS) || reject_count !== 32'(STATS)) begin
      errors++;
      $display("FAIL wrap_end: got valid=%b full=%b acc=%0d rej=%0d, want 0 0 %0d %0d",
               out_valid, verdict_full, accept_count, reject_count, 4*STATS, STATS);
    end
  endtask

  task automatic test_both_and_reset_mid();
    do_reset();
    out_ready = 1'b0;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b, want 0", proto_err);
    end
    push_one(1'b1, 1'b1, 16'd99);
    checks++;
    if (out_valid !== 1'b1 || out_accept !== 1'b0 || out_len !== 16'd99 || proto_err !== 1'b1 ||
        reject_count !== 32'(STATS) || accept_count !== 32'd0 || cpu_done !== 1'b1) begin
      errors++;
      $display("FAIL both_high: got valid=%b %b/%0d err=%b rej=%0d acc=%0d done=%b, want 1 0/99 1 %0d 0 1",
               out_valid, out_accept, out_len, proto_err, reject_count, accept_count, cpu_done, STATS);
    end
    push_one(1'b1, 1'b0, 16'd7);
    push_one(1'b1, 1'b0, 16'd8);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || verdict_full !== 1'b0 || cpu_done !== 1'b0 || proto_err !== 1'b0 ||
        accept_count !== 0 || reject_count !== 0 || drop_count !== 0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b full=%b done=%b err=%b cnt=%0d/%0d/%0d, want all 0",
               out_valid, verdict_full, cpu_done, proto_err, accept_count, reject_count, drop_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got valid=%b, want 0", out_valid);
    end
    $display("test_both_and_reset_mid done");
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fill_drop_drain();
    test_full_pop();
    test_both_and_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
